// File: rtl/counter_pkg.sv
// Shared definitions for the counter primitives: state encoding, mode names
// and implementation-select names (also used by the up-counter).
package counter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam string MODE_ONE_SHOT    = "ONE_SHOT";
    localparam string MODE_AUTO_RELOAD = "AUTO_RELOAD";

    localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
    localparam string ARCH_VIRTEX5    = "VIRTEX5";
    localparam string ARCH_VIRTEX6    = "VIRTEX6";

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with valid/ready load, saturating decrement by STEP
// and a registered one-cycle terminal-count pulse; one-shot or auto-reload.
module down_counter_timer
    import counter_pkg::*;
#(
    parameter string       ARCHITECTURE = "BEHAVIORAL",
    parameter string       MODE         = "ONE_SHOT",
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned STEP         = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output logic                  tc,
    output logic [DATA_WIDTH-1:0] reload_val
);

    localparam bit                    AUTO_RELOAD = (MODE == MODE_AUTO_RELOAD);
    localparam logic [DATA_WIDTH-1:0] STEP_W      = DATA_WIDTH'(STEP);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [DATA_WIDTH-1:0]   reload_q, reload_d;
    logic                    tc_q, tc_d;
    logic                    accept;

    // DSP48-based variants will live in these arms; today every build uses the fabric logic below.
    generate
        if (ARCHITECTURE == ARCH_VIRTEX5) begin : g_virtex5
        end else if (ARCHITECTURE == ARCH_VIRTEX6) begin : g_virtex6
        end else begin : g_behavioral
        end
    endgenerate

    always_comb begin
        if (clr) begin
            load_ready = 1'b0;
        end else if (state_q == IDLE) begin
            load_ready = 1'b1;
        end else begin
            load_ready = AUTO_RELOAD;
        end
    end

    assign accept = load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (clr) begin
            state_d = IDLE;
            out_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_d    = load_value;
                        reload_d = load_value;
                        // A zero load is a zero-length timer: fire tc without entering COUNT.
                        if (load_value == '0) begin
                            tc_d = 1'b1;
                        end else begin
                            state_d = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (accept) begin
                        reload_d = load_value;
                    end
                    if (en) begin
                        if (out_q > STEP_W) begin
                            out_d = out_q - STEP_W;
                        end else begin
                            tc_d = 1'b1;
                            // reload_d already carries a load accepted on this same edge.
                            if (AUTO_RELOAD && (reload_d != '0)) begin
                                out_d = reload_d;
                            end else begin
                                out_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign out        = out_q;
    assign busy       = (state_q == COUNT);
    assign tc         = tc_q;
    assign reload_val = reload_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Three timer variants (one-shot step 1, auto-reload step 1, one-shot step 4) on shared
// inputs, each compared every cycle against a per-variant reference model.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load_valid;
    logic [7:0] load_value;

    always #5 clk = ~clk;

    logic [7:0] out0, out1, out2, rel0, rel1, rel2;
    logic       busy0, busy1, busy2, tc0, tc1, tc2, rdy0, rdy1, rdy2;

    down_counter_timer #(.ARCHITECTURE("BEHAVIORAL"), .MODE("ONE_SHOT"), .DATA_WIDTH(8), .STEP(1)) u_os (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load_valid(load_valid),
        .load_ready(rdy0), .load_value(load_value), .out(out0), .busy(busy0),
        .tc(tc0), .reload_val(rel0));

    down_counter_timer #(.ARCHITECTURE("BEHAVIORAL"), .MODE("AUTO_RELOAD"), .DATA_WIDTH(8), .STEP(1)) u_ar (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load_valid(load_valid),
        .load_ready(rdy1), .load_value(load_value), .out(out1), .busy(busy1),
        .tc(tc1), .reload_val(rel1));

    down_counter_timer #(.ARCHITECTURE("BEHAVIORAL"), .MODE("ONE_SHOT"), .DATA_WIDTH(8), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load_valid(load_valid),
        .load_ready(rdy2), .load_value(load_value), .out(out2), .busy(busy2),
        .tc(tc2), .reload_val(rel2));

    logic [7:0] d_out [3];
    logic [7:0] d_rel [3];
    logic       d_busy[3];
    logic       d_tc  [3];
    logic       d_rdy [3];

    assign d_out[0] = out0;  assign d_out[1] = out1;  assign d_out[2] = out2;
    assign d_rel[0] = rel0;  assign d_rel[1] = rel1;  assign d_rel[2] = rel2;
    assign d_busy[0] = busy0; assign d_busy[1] = busy1; assign d_busy[2] = busy2;
    assign d_tc[0] = tc0;    assign d_tc[1] = tc1;    assign d_tc[2] = tc2;
    assign d_rdy[0] = rdy0;  assign d_rdy[1] = rdy1;  assign d_rdy[2] = rdy2;

    int ncomp = 0;
    int nfail = 0;

    // Reference model: remaining count, remembered reload value, running flag, tc pulse.
    int m_cnt [3];
    int m_rel [3];
    bit m_run [3];
    bit m_tc  [3];
    bit m_auto[3] = '{1'b0, 1'b1, 1'b0};
    int m_step[3] = '{1, 1, 4};

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int i, input bit c);
        return !c && (!m_run[i] || m_auto[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 1'b0; m_tc[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = load_valid && m_ready(i, clr);
            m_tc[i] = 1'b0;
            if (clr) begin
                m_run[i] = 1'b0;
                m_cnt[i] = 0;
            end else if (!m_run[i]) begin
                if (acc) begin
                    m_cnt[i] = int'(load_value);
                    m_rel[i] = int'(load_value);
                    m_run[i] = (load_value != 0);
                    m_tc[i]  = (load_value == 0);
                end
            end else begin
                if (acc) m_rel[i] = int'(load_value);
                if (en) begin
                    if (m_cnt[i] > m_step[i]) begin
                        m_cnt[i] = m_cnt[i] - m_step[i];
                    end else begin
                        m_tc[i] = 1'b1;
                        if (m_auto[i] && m_rel[i] != 0) begin
                            m_cnt[i] = m_rel[i];
                        end else begin
                            m_cnt[i] = 0;
                            m_run[i] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check("out", i, d_out[i], m_cnt[i]);
            check("busy", i, d_busy[i], m_run[i]);
            check("tc", i, d_tc[i], m_tc[i]);
            check("reload_val", i, d_rel[i], m_rel[i]);
        end
    endtask

    // Drive one cycle of inputs, check the combinational ready, then the registered result.
    task automatic cycle(input bit e, input bit c, input bit lv, input int v);
        en = e; clr = c; load_valid = lv; load_value = 8'(v);
        #1;
        for (int i = 0; i < 3; i++) check("load_ready", i, d_rdy[i], m_ready(i, c));
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load_valid = 1'b0; load_value = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // One-shot countdown from 5.
        cycle(1, 0, 1, 5);
        check("os_load", 0, out0, 5);
        for (int k = 4; k >= 0; k--) begin
            cycle(1, 0, 0, 0);
            check("os_seq", 0, out0, k);
            check("os_tc", 0, tc0, (k == 0));
        end
        check("os_idle_busy", 0, busy0, 0);
        cycle(1, 0, 0, 0);

        // Auto-reload 3, then a mid-count reload of 6.
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 3);
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0);
        check("ar_rdy_mid", 1, rdy1, 1);
        cycle(1, 0, 1, 6);
        for (int k = 0; k < 9; k++) cycle(1, 0, 0, 0);

        // Step 4 from 10 saturates at zero.
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 10);
        check("s4_seq", 2, out2, 10);
        cycle(1, 0, 0, 0); check("s4_seq", 2, out2, 6);
        cycle(1, 0, 0, 0); check("s4_seq", 2, out2, 2);
        cycle(1, 0, 0, 0); check("s4_seq", 2, out2, 0);
        check("s4_tc", 2, tc2, 1);

        // Enable gating, then clr beating a concurrent load.
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 4);
        cycle(1, 0, 0, 0); check("en_seq", 0, out0, 3);
        cycle(0, 0, 0, 0); check("en_seq", 0, out0, 3);
        cycle(0, 0, 0, 0); check("en_seq", 0, out0, 3);
        cycle(1, 0, 0, 0); check("en_seq", 0, out0, 2);
        cycle(1, 1, 1, 9);
        check("clr_out", 0, out0, 0);
        check("clr_busy", 0, busy0, 0);

        // Zero-length load.
        cycle(1, 0, 1, 0);
        check("zero_tc", 0, tc0, 1);
        check("zero_busy", 0, busy0, 0);
        cycle(1, 0, 0, 0);
        check("zero_tc_end", 0, tc0, 0);

        // Asynchronous reset mid-count at out=7.
        cycle(1, 0, 1, 10);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
        check("pre_rst", 0, out0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_out", 0, out0, 0);
        check("arst_busy", 0, busy0, 0);
        check("arst_tc", 0, tc0, 0);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int v;
            v = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            if ($urandom_range(0, 15) == 0) v = int'($urandom_range(200, 255));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 4) == 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
